logo_mem_port: RTL and testbench

Bus-side initiator for the 16 KiB logo memory, the block that drives its address/data/write-enable port and consumes its one-cycle-latency read data. It turns asynchronous MSX slot strobes into single, cleanly timed memory accesses and returns read data onto the slot data bus. It supports ROM mode (writes blocked) and RAM mode. It sits between the slot bus decoder and the memory instance, on the memory's clock.

---
 rtl/logo_mem_port.sv | 135 +++++++++++++
 tb/tb_logo_mem_port.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/logo_mem_port.sv
// Slot-bus initiator for the 16 KiB logo memory: synchronizes MSX strobes,
// issues one timed memory access per strobe and drives read data back onto the bus.
module logo_mem_port #(
  parameter logic [1:0] BASE_PAGE = 2'd1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        bus_sel_n,
  input  logic        bus_rd_n,
  input  logic        bus_wr_n,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_data_in,
  input  logic        write_enable,
  output logic [7:0]  bus_data_out,
  output logic        bus_data_oe,
  output logic [13:0] mem_address,
  output logic [7:0]  mem_data,
  output logic        mem_wren,
  input  logic [7:0]  mem_q
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_WAIT, RD_HOLD, WR_PULSE, WR_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  sel_sync_q, sel_sync_d;
  logic [1:0]  rd_sync_q, rd_sync_d;
  logic [1:0]  wr_sync_q, wr_sync_d;
  logic [1:0]  flush_q, flush_d;
  logic        rd_prev_q, rd_prev_d;
  logic        wr_prev_q, wr_prev_d;
  logic [7:0]  bus_data_out_q, bus_data_out_d;
  logic        bus_data_oe_q, bus_data_oe_d;
  logic [13:0] mem_address_q, mem_address_d;
  logic [7:0]  mem_data_q, mem_data_d;
  logic        mem_wren_q, mem_wren_d;

  logic sel_s, rd_s, wr_s, rd_fall, wr_fall, hit;

  // NOTE: raw strobes are asynchronous; only the second synchronizer stage may feed logic.
  assign sel_s = sel_sync_q[1];
  assign rd_s  = rd_sync_q[1];
  assign wr_s  = wr_sync_q[1];

  assign rd_fall = rd_prev_q & ~rd_s;
  assign wr_fall = wr_prev_q & ~wr_s;
  assign hit     = ~sel_s && (bus_addr[15:14] == BASE_PAGE) && (state_q == IDLE);

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves a variable unassigned (no latches).
    sel_sync_d     = {sel_sync_q[0], bus_sel_n};
    rd_sync_d      = {rd_sync_q[0], bus_rd_n};
    wr_sync_d      = {wr_sync_q[0], bus_wr_n};
    flush_d        = {flush_q[0], 1'b1};
    // Until the chains hold real bus levels, their reset 1s must not look like a released strobe.
    rd_prev_d      = flush_q[1] ? rd_s : 1'b0;
    wr_prev_d      = flush_q[1] ? wr_s : 1'b0;
    state_d        = state_q;
    bus_data_out_d = bus_data_out_q;
    bus_data_oe_d  = bus_data_oe_q;
    mem_address_d  = mem_address_q;
    mem_data_d     = mem_data_q;
    mem_wren_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hit && rd_fall) begin
          state_d       = RD_ADDR;
          mem_address_d = bus_addr[13:0];
        end else if (hit && wr_fall) begin
          state_d       = WR_PULSE;
          mem_address_d = bus_addr[13:0];
          mem_data_d    = bus_data_in;
          mem_wren_d    = write_enable;
        end
      end
      RD_ADDR: state_d = RD_WAIT;
      RD_WAIT: begin
        bus_data_out_d = mem_q;
        bus_data_oe_d  = 1'b1;
        state_d        = RD_HOLD;
      end
      RD_HOLD: begin
        if (rd_s || sel_s) begin
          bus_data_oe_d = 1'b0;
          state_d       = IDLE;
        end
      end
      WR_PULSE: state_d = WR_HOLD;
      WR_HOLD: begin
        if (wr_s || sel_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      sel_sync_q     <= 2'b11;
      rd_sync_q      <= 2'b11;
      wr_sync_q      <= 2'b11;
      flush_q        <= 2'b00;
      rd_prev_q      <= 1'b0;
      wr_prev_q      <= 1'b0;
      bus_data_out_q <= 8'h00;
      bus_data_oe_q  <= 1'b0;
      mem_address_q  <= 14'h0000;
      mem_data_q     <= 8'h00;
      mem_wren_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_sync_q     <= sel_sync_d;
      rd_sync_q      <= rd_sync_d;
      wr_sync_q      <= wr_sync_d;
      flush_q        <= flush_d;
      rd_prev_q      <= rd_prev_d;
      wr_prev_q      <= wr_prev_d;
      bus_data_out_q <= bus_data_out_d;
      bus_data_oe_q  <= bus_data_oe_d;
      mem_address_q  <= mem_address_d;
      mem_data_q     <= mem_data_d;
      mem_wren_q     <= mem_wren_d;
    end
  end

  assign bus_data_out = bus_data_out_q;
  assign bus_data_oe  = bus_data_oe_q;
  assign mem_address  = mem_address_q;
  assign mem_data     = mem_data_q;
  assign mem_wren     = mem_wren_q;

endmodule

// File: tb/tb_logo_mem_port.sv
// Scoreboard bench for logo_mem_port: a behavioural memory, directed slot-bus
// accesses, and a monitor that checks every read presentation and write pulse.
module tb_logo_mem_port;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        bus_sel_n, bus_rd_n, bus_wr_n;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_in;
  logic        write_enable;
  logic [7:0]  bus_data_out;
  logic        bus_data_oe;
  logic [13:0] mem_address;
  logic [7:0]  mem_data;
  logic        mem_wren;
  logic [7:0]  mem_q;

  logic [7:0]  mem [0:16383];
  logic [7:0]  exp_rd_q [$];
  logic [21:0] exp_wr_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        oe_prev  = 1'b0;

  logo_mem_port #(.BASE_PAGE(2'd1)) dut (
    .clock(clock), .reset_n(reset_n),
    .bus_sel_n(bus_sel_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
    .bus_addr(bus_addr), .bus_data_in(bus_data_in), .write_enable(write_enable),
    .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // One-cycle-latency synchronous memory.
  always @(posedge clock) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    mem_q <= mem[mem_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each new read presentation and each write pulse against the queues.
  always @(negedge clock) begin
    if (bus_data_oe && !oe_prev) begin
      if (exp_rd_q.size() == 0) check("unexpected_read", {24'h0, bus_data_out}, 32'hFFFF_FFFF);
      else check("read_data", {24'h0, bus_data_out}, {24'h0, exp_rd_q.pop_front()});
    end
    oe_prev = bus_data_oe;
    if (mem_wren) begin
      if (exp_wr_q.size() == 0) check("unexpected_write", {10'h0, mem_address, mem_data}, 32'hFFFF_FFFF);
      else check("write_addr_data", {10'h0, mem_address, mem_data}, {10'h0, exp_wr_q.pop_front()});
    end
  end

  task automatic do_read(input logic [15:0] addr, input logic [7:0] exp, input int hold, input bit timing);
    @(posedge clock); #2;
    bus_addr = addr; bus_sel_n = 1'b0; bus_rd_n = 1'b0;
    exp_rd_q.push_back(exp);
    if (timing) begin
      repeat (3) @(posedge clock); #1;
      check("rd_addr_cycle1", {18'h0, mem_address}, {18'h0, addr[13:0]});
      @(posedge clock); #1;
      check("rd_oe_cycle2", {31'h0, bus_data_oe}, 32'h0);
      @(posedge clock); #1;
      check("rd_oe_cycle3", {31'h0, bus_data_oe}, 32'h1);
      check("rd_data_cycle3", {24'h0, bus_data_out}, {24'h0, exp});
    end
    repeat (hold) @(posedge clock);
    @(posedge clock); #2;
    bus_rd_n = 1'b1; bus_sel_n = 1'b1;
    if (timing) begin
      repeat (2) @(posedge clock); #1;
      check("rd_oe_before_drop", {31'h0, bus_data_oe}, 32'h1);
      @(posedge clock); #1;
      check("rd_oe_dropped", {31'h0, bus_data_oe}, 32'h0);
    end
    repeat (4) @(posedge clock);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input logic we,
                          input int hold, input bit flip_we);
    @(posedge clock); #2;
    bus_addr = addr; bus_data_in = data; write_enable = we;
    bus_sel_n = 1'b0; bus_wr_n = 1'b0;
    if (we) exp_wr_q.push_back({addr[13:0], data});
    repeat (3) @(posedge clock); #1;
    check("wr_addr_cycle1", {18'h0, mem_address}, {18'h0, addr[13:0]});
    check("wr_data_cycle1", {24'h0, mem_data}, {24'h0, data});
    check("wr_wren_cycle1", {31'h0, mem_wren}, {31'h0, we});
    if (flip_we) write_enable = ~we;
    repeat (hold) @(posedge clock);
    @(posedge clock); #2;
    bus_wr_n = 1'b1; bus_sel_n = 1'b1; write_enable = 1'b1;
    repeat (4) @(posedge clock);
  endtask

  task automatic do_miss(input logic [15:0] addr, input logic sel_n, input string name);
    logic [13:0] addr_before;
    @(posedge clock); #2;
    addr_before = mem_address;
    bus_addr = addr; bus_sel_n = sel_n; bus_rd_n = 1'b0;
    repeat (8) @(posedge clock); #1;
    check({name, "_oe"}, {31'h0, bus_data_oe}, 32'h0);
    check({name, "_addr"}, {18'h0, mem_address}, {18'h0, addr_before});
    @(posedge clock); #2;
    bus_rd_n = 1'b1; bus_sel_n = 1'b1;
    repeat (4) @(posedge clock);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h0000] = 8'h77;
    mem[14'h0010] = 8'h3C;
    mem[14'h0123] = 8'hA5;
    mem[14'h3FFE] = 8'h22;
    reset_n = 1'b0; bus_sel_n = 1'b1; bus_rd_n = 1'b1; bus_wr_n = 1'b1;
    bus_addr = 16'h0000; bus_data_in = 8'h00; write_enable = 1'b1;

    repeat (2) @(posedge clock); #1;
    check("rst_data_out", {24'h0, bus_data_out}, 32'h0);
    check("rst_oe", {31'h0, bus_data_oe}, 32'h0);
    check("rst_mem_address", {18'h0, mem_address}, 32'h0);
    check("rst_mem_data", {24'h0, mem_data}, 32'h0);
    check("rst_wren", {31'h0, mem_wren}, 32'h0);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clock);

    // Basic read with cycle-accurate timing.
    do_read(16'h4123, 8'hA5, 3, 1'b1);

    // RAM write held 10 clocks, then read back.
    do_write(16'h7FFF, 8'h5A, 1'b1, 10, 1'b0);
    do_read(16'h7FFF, 8'h5A, 2, 1'b0);

    // ROM write: dropped, even though write_enable rises mid-access.
    do_write(16'h7FFE, 8'hC3, 1'b0, 10, 1'b1);
    do_read(16'h7FFE, 8'h22, 2, 1'b0);

    // Early strobe release: access still completes.
    do_read(16'h4000, 8'h77, 0, 1'b0);

    // Decode misses.
    do_miss(16'h8000, 1'b0, "miss_page");
    do_miss(16'h4000, 1'b1, "miss_sel");

    // Reset during RD_HOLD with the read strobe held low.
    @(posedge clock); #2;
    bus_addr = 16'h4010; bus_sel_n = 1'b0; bus_rd_n = 1'b0;
    exp_rd_q.push_back(8'h3C);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clock); #1;
        seen = bus_data_oe;
      end
      check("rst_rd_oe_seen", {31'h0, seen}, 32'h1);
    end
    repeat (2) @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    check("midrst_oe", {31'h0, bus_data_oe}, 32'h0);
    check("midrst_addr", {18'h0, mem_address}, 32'h0);
    @(posedge clock); #2;
    reset_n = 1'b1;
    repeat (10) @(posedge clock); #1;
    check("postrst_no_access_oe", {31'h0, bus_data_oe}, 32'h0);
    check("postrst_no_access_addr", {18'h0, mem_address}, 32'h0);
    @(posedge clock); #2;
    bus_rd_n = 1'b1; bus_sel_n = 1'b1;
    repeat (4) @(posedge clock);
    do_read(16'h4010, 8'h3C, 2, 1'b0);

    // Read and write strobes fall together: read wins, write dropped.
    @(posedge clock); #2;
    bus_addr = 16'h4010; bus_data_in = 8'h99; write_enable = 1'b1;
    bus_sel_n = 1'b0; bus_rd_n = 1'b0; bus_wr_n = 1'b0;
    exp_rd_q.push_back(8'h3C);
    repeat (5) @(posedge clock); #1;
    check("simul_oe", {31'h0, bus_data_oe}, 32'h1);
    check("simul_data", {24'h0, bus_data_out}, 32'h3C);
    check("simul_wren", {31'h0, mem_wren}, 32'h0);
    repeat (3) @(posedge clock); #2;
    bus_rd_n = 1'b1; bus_wr_n = 1'b1; bus_sel_n = 1'b1;
    repeat (6) @(posedge clock); #1;
    check("simul_oe_released", {31'h0, bus_data_oe}, 32'h0);
    check("simul_mem_untouched", {24'h0, mem[14'h0010]}, 32'h3C);

    check("rd_queue_drained", exp_rd_q.size(), 32'h0);
    check("wr_queue_drained", exp_wr_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
